// File: rtl/imm_gen_pipe_if.sv
// ============================================================================
// Module      : imm_gen_pipe_if
// Description : Valid/ready bundle between an instruction producer, the
//               immediate generator and the downstream consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [2:0]      inst_type;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] immediate;
    logic [2:0]      out_fmt;
    logic            out_illegal;
    logic [31:0]     out_instr;

    // Producer/consumer side (drives requests, consumes results)
    modport master (
        output in_valid, instruction, inst_type, out_ready,
        input  in_ready, out_valid, immediate, out_fmt, out_illegal, out_instr
    );

    // Immediate generator side
    modport slave (
        input  in_valid, instruction, inst_type, out_ready,
        output in_ready, out_valid, immediate, out_fmt, out_illegal, out_instr
    );
endinterface

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module      : imm_gen_pipe
// Description : RISC-V immediate generator behind an output register plus a
//               skid register. Optional macro IMM_GEN_RVC_EN adds RVC decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter int AUTO_DECODE = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    imm_gen_pipe_if.slave bus
);

    localparam logic [2:0] FMT_I   = 3'b000;
    localparam logic [2:0] FMT_S   = 3'b001;
    localparam logic [2:0] FMT_B   = 3'b010;
    localparam logic [2:0] FMT_U   = 3'b011;
    localparam logic [2:0] FMT_J   = 3'b100;
    localparam logic [2:0] FMT_R   = 3'b101;
    localparam logic [2:0] FMT_C   = 3'b110;
    localparam logic [2:0] FMT_ILL = 3'b111;

    // Stored item: {instr, illegal, fmt, immediate}
    localparam int DW = XLEN + 36;

    logic [31:0] ins;
    assign ins = bus.instruction;

    // Immediates are built at 64 bits and truncated to XLEN at capture
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    assign imm_i = {{52{ins[31]}}, ins[31:20]};
    assign imm_s = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {{32{ins[31]}}, ins[31:12], 12'b0};
    assign imm_j = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    generate
        if (XLEN == 64) begin : g_shamt64
            assign imm_sh = {58'b0, ins[25:20]};
        end else begin : g_shamt32
            assign imm_sh = {59'b0, ins[24:20]};
        end
    endgenerate

`ifdef IMM_GEN_RVC_EN
    logic [63:0] imm_c6, imm_clui, imm_cj, imm_cb, imm_clw;
    assign imm_c6   = {{58{ins[12]}}, ins[12], ins[6:2]};
    assign imm_clui = {{46{ins[12]}}, ins[12], ins[6:2], 12'b0};
    assign imm_cj   = {{52{ins[12]}}, ins[12], ins[8], ins[10:9], ins[6], ins[7],
                       ins[2], ins[11], ins[5:3], 1'b0};
    assign imm_cb   = {{55{ins[12]}}, ins[12], ins[6:5], ins[2], ins[11:10],
                       ins[4:3], 1'b0};
    assign imm_clw  = {57'b0, ins[5], ins[12:10], ins[6], 2'b00};
`endif

    logic [63:0] dec_imm;
    logic [2:0]  dec_fmt;
    logic        dec_ill;

    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_ILL;
        dec_ill = 1'b1;
        if (AUTO_DECODE != 0) begin
            if (ins[1:0] == 2'b11) begin
                dec_fmt = FMT_I;
                dec_ill = 1'b0;
                case (ins[6:0])
                    7'b0010011: dec_imm = (ins[13:12] == 2'b01) ? imm_sh : imm_i;
                    7'b0000011,
                    7'b1100111,
                    7'b1110011: dec_imm = imm_i;
                    7'b0100011: begin dec_imm = imm_s; dec_fmt = FMT_S; end
                    7'b1100011: begin dec_imm = imm_b; dec_fmt = FMT_B; end
                    7'b0110111,
                    7'b0010111: begin dec_imm = imm_u; dec_fmt = FMT_U; end
                    7'b1101111: begin dec_imm = imm_j; dec_fmt = FMT_J; end
                    7'b0110011: dec_fmt = FMT_R;
                    default: begin dec_fmt = FMT_ILL; dec_ill = 1'b1; end
                endcase
            end else begin
`ifdef IMM_GEN_RVC_EN
                dec_fmt = FMT_C;
                dec_ill = 1'b0;
                case ({ins[1:0], ins[15:13]})
                    5'b01_000, 5'b01_010: dec_imm = imm_c6;
                    5'b01_011: begin
                        // rd==x2 here is C.ADDI16SP, which is not supported
                        if (ins[11:7] != 5'd2) begin
                            dec_imm = imm_clui;
                        end else begin
                            dec_fmt = FMT_ILL;
                            dec_ill = 1'b1;
                        end
                    end
                    5'b01_001, 5'b01_101: dec_imm = imm_cj;
                    5'b01_110, 5'b01_111: dec_imm = imm_cb;
                    5'b00_010, 5'b00_110: dec_imm = imm_clw;
                    default: begin dec_fmt = FMT_ILL; dec_ill = 1'b1; end
                endcase
`endif
            end
        end else begin
            dec_ill = 1'b0;
            case (bus.inst_type)
                FMT_I:   begin dec_imm = imm_i; dec_fmt = FMT_I; end
                FMT_S:   begin dec_imm = imm_s; dec_fmt = FMT_S; end
                FMT_B:   begin dec_imm = imm_b; dec_fmt = FMT_B; end
                FMT_U:   begin dec_imm = imm_u; dec_fmt = FMT_U; end
                FMT_J:   begin dec_imm = imm_j; dec_fmt = FMT_J; end
                default: begin dec_fmt = FMT_ILL; dec_ill = 1'b1; end
            endcase
        end
    end

    logic [DW-1:0] new_item;
    assign new_item = {ins, dec_ill, dec_fmt, dec_imm[XLEN-1:0]};

    logic          or_valid_q, or_valid_d;
    logic [DW-1:0] or_data_q,  or_data_d;
    logic          sk_valid_q, sk_valid_d;
    logic [DW-1:0] sk_data_q,  sk_data_d;

    logic accept, or_free;
    assign accept  = bus.in_valid && !sk_valid_q;
    assign or_free = !or_valid_q || bus.out_ready;

    always_comb begin
        or_valid_d = or_valid_q;
        or_data_d  = or_data_q;
        sk_valid_d = sk_valid_q;
        sk_data_d  = sk_data_q;
        if (or_free) begin
            // The skid entry is older than anything arriving this cycle
            if (sk_valid_q) begin
                or_valid_d = 1'b1;
                or_data_d  = sk_data_q;
                sk_valid_d = accept;
                if (accept) begin
                    sk_data_d = new_item;
                end
            end else begin
                or_valid_d = accept;
                if (accept) begin
                    or_data_d = new_item;
                end
            end
        end else if (accept) begin
            sk_valid_d = 1'b1;
            sk_data_d  = new_item;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            or_valid_q <= 1'b0;
            or_data_q  <= '0;
            sk_valid_q <= 1'b0;
            sk_data_q  <= '0;
        end else begin
            or_valid_q <= or_valid_d;
            or_data_q  <= or_data_d;
            sk_valid_q <= sk_valid_d;
            sk_data_q  <= sk_data_d;
        end
    end

    assign bus.in_ready    = !sk_valid_q;
    assign bus.out_valid   = or_valid_q;
    assign bus.out_instr   = or_data_q[DW-1 -: 32];
    assign bus.out_illegal = or_data_q[XLEN+3];
    assign bus.out_fmt     = or_data_q[XLEN+2 -: 3];
    assign bus.immediate   = or_data_q[XLEN-1:0];

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module      : tb_imm_gen_pipe
// Description : Directed vector table plus backpressure/reset sequences for
//               imm_gen_pipe (XLEN=32, XLEN=64 and manual-format instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) b32 ();
    imm_gen_pipe_if #(.XLEN(64)) b64 ();
    imm_gen_pipe_if #(.XLEN(32)) bm  ();

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1)) u32 (.clk(clk), .rst(rst), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1)) u64 (.clk(clk), .rst(rst), .bus(b64));
    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0)) um  (.clk(clk), .rst(rst), .bus(bm));

    typedef struct {
        logic [1:0]  sel;    // 0: XLEN32 auto, 1: XLEN64 auto, 2: XLEN32 manual
        logic [31:0] instr;
        logic [2:0]  itype;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    localparam int NV = 19;
    vec_t vt [NV];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_all();
        b32.in_valid = 1'b0; b64.in_valid = 1'b0; bm.in_valid = 1'b0;
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        logic [63:0] g_imm;
        logic [36:0] g_misc;
        @(negedge clk);
        b32.instruction = v.instr; b64.instruction = v.instr; bm.instruction = v.instr;
        b32.inst_type = v.itype;   b64.inst_type = v.itype;   bm.inst_type = v.itype;
        case (v.sel)
            2'd0:    b32.in_valid = 1'b1;
            2'd1:    b64.in_valid = 1'b1;
            default: bm.in_valid  = 1'b1;
        endcase
        @(posedge clk);
        #1 idle_all();
        @(negedge clk);
        case (v.sel)
            2'd0: begin
                g_imm  = {32'b0, b32.immediate};
                g_misc = {b32.out_valid, b32.out_illegal, b32.out_fmt, b32.out_instr};
            end
            2'd1: begin
                g_imm  = b64.immediate;
                g_misc = {b64.out_valid, b64.out_illegal, b64.out_fmt, b64.out_instr};
            end
            default: begin
                g_imm  = {32'b0, bm.immediate};
                g_misc = {bm.out_valid, bm.out_illegal, bm.out_fmt, bm.out_instr};
            end
        endcase
        chk($sformatf("vec%0d_imm", idx), g_imm, v.imm);
        chk($sformatf("vec%0d_valid_ill_fmt_instr", idx), {27'b0, g_misc},
            {27'b0, 1'b1, v.ill, v.fmt, v.instr});
    endtask

    initial begin
        vt[0]  = '{2'd0, 32'hFFF00093, 3'd0, 64'h00000000FFFFFFFF, 3'b000, 1'b0};
        vt[1]  = '{2'd0, 32'hFE112E23, 3'd0, 64'h00000000FFFFFFFC, 3'b001, 1'b0};
        vt[2]  = '{2'd0, 32'hFF9FF06F, 3'd0, 64'h00000000FFFFFFF8, 3'b100, 1'b0};
        vt[3]  = '{2'd0, 32'h41F0D093, 3'd0, 64'h000000000000001F, 3'b000, 1'b0};
        vt[4]  = '{2'd0, 32'h4200D093, 3'd0, 64'h0000000000000000, 3'b000, 1'b0};
        vt[5]  = '{2'd0, 32'h800002B7, 3'd0, 64'h0000000080000000, 3'b011, 1'b0};
        vt[6]  = '{2'd0, 32'hFE000EE3, 3'd0, 64'h00000000FFFFFFFC, 3'b010, 1'b0};
        vt[7]  = '{2'd0, 32'h00B50533, 3'd0, 64'h0000000000000000, 3'b101, 1'b0};
        vt[8]  = '{2'd0, 32'h0000007F, 3'd0, 64'h0000000000000000, 3'b111, 1'b1};
`ifdef IMM_GEN_RVC_EN
        vt[9]  = '{2'd0, 32'h000050FD, 3'd0, 64'h00000000FFFFFFFF, 3'b110, 1'b0};
        vt[10] = '{2'd0, 32'h000040C0, 3'd0, 64'h0000000000000004, 3'b110, 1'b0};
        vt[18] = '{2'd0, 32'h0000BFFD, 3'd0, 64'h00000000FFFFFFFE, 3'b110, 1'b0};
`else
        vt[9]  = '{2'd0, 32'h000050FD, 3'd0, 64'h0000000000000000, 3'b111, 1'b1};
        vt[10] = '{2'd0, 32'h000040C0, 3'd0, 64'h0000000000000000, 3'b111, 1'b1};
        vt[18] = '{2'd0, 32'h0000BFFD, 3'd0, 64'h0000000000000000, 3'b111, 1'b1};
`endif
        vt[11] = '{2'd1, 32'h800002B7, 3'd0, 64'hFFFFFFFF80000000, 3'b011, 1'b0};
        vt[12] = '{2'd1, 32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 3'b000, 1'b0};
        vt[13] = '{2'd1, 32'h4200D093, 3'd0, 64'h0000000000000020, 3'b000, 1'b0};
        vt[14] = '{2'd2, 32'hFE112E23, 3'd1, 64'h00000000FFFFFFFC, 3'b001, 1'b0};
        vt[15] = '{2'd2, 32'h800002B7, 3'd3, 64'h0000000080000000, 3'b011, 1'b0};
        vt[16] = '{2'd2, 32'hFFF00093, 3'd6, 64'h0000000000000000, 3'b111, 1'b1};
        vt[17] = '{2'd2, 32'h00B50533, 3'd0, 64'h000000000000000B, 3'b000, 1'b0};

        idle_all();
        b32.instruction = '0; b64.instruction = '0; bm.instruction = '0;
        b32.inst_type = '0;   b64.inst_type = '0;   bm.inst_type = '0;
        b32.out_ready = 1'b1; b64.out_ready = 1'b1; bm.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset32_state", {26'b0, b32.out_valid, b32.in_ready, b32.out_fmt,
            b32.out_illegal, b32.out_instr}, {26'b0, 1'b0, 1'b1, 3'b000, 1'b0, 32'h0});
        chk("reset32_imm", {32'b0, b32.immediate}, 64'h0);
        chk("reset64_imm", b64.immediate, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply_vec(i, vt[i]);
        end
        @(negedge clk);
        chk("drained_valid", {63'b0, b32.out_valid}, 64'h0);

        // Backpressure: A to OR, B to skid, C blocked until space frees
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.instruction = 32'hFFF00093;
        chk("bp_ready_before_A", {63'b0, b32.in_ready}, 64'h1);
        @(posedge clk);
        @(negedge clk);
        chk("bp_A_out", {31'b0, b32.out_valid, b32.out_instr}, {31'b0, 1'b1, 32'hFFF00093});
        chk("bp_ready_before_B", {63'b0, b32.in_ready}, 64'h1);
        b32.instruction = 32'hFE112E23;
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready_after_2", {63'b0, b32.in_ready}, 64'h0);
        b32.instruction = 32'hFF9FF06F;
        @(posedge clk);
        @(negedge clk);
        chk("bp_A_hold", {b32.out_valid, b32.out_illegal, b32.out_fmt, 27'b0, b32.immediate},
            {1'b1, 1'b0, 3'b000, 27'b0, 32'hFFFFFFFF});
        chk("bp_A_hold_instr", {32'b0, b32.out_instr}, {32'b0, 32'hFFF00093});
        b32.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_B_out", {31'b0, b32.out_valid, b32.out_instr}, {31'b0, 1'b1, 32'hFE112E23});
        chk("bp_B_imm", {32'b0, b32.immediate}, 64'h00000000FFFFFFFC);
        chk("bp_ready_freed", {63'b0, b32.in_ready}, 64'h1);
        @(posedge clk);
        #1 b32.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_C_out", {31'b0, b32.out_valid, b32.out_instr}, {31'b0, 1'b1, 32'hFF9FF06F});
        @(posedge clk);
        @(negedge clk);
        chk("bp_empty", {63'b0, b32.out_valid}, 64'h0);

        // Mid-operation reset with both registers full and input offered
        b32.out_ready = 1'b0;
        b32.in_valid = 1'b1; b32.instruction = 32'hFFF00093;
        @(posedge clk);
        @(negedge clk);
        b32.instruction = 32'h800002B7;
        @(posedge clk);
        @(negedge clk);
        chk("rst_pre_full", {63'b0, b32.in_ready}, 64'h0);
        rst = 1'b1;
        b32.instruction = 32'hFE112E23;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        b32.in_valid = 1'b0;
        b32.out_ready = 1'b1;
        chk("rst_mid_state", {27'b0, b32.out_valid, b32.in_ready, b32.out_fmt, b32.out_instr},
            {27'b0, 1'b0, 1'b1, 3'b000, 32'h0});
        chk("rst_mid_imm", {32'b0, b32.immediate}, 64'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_no_accept", {63'b0, b32.out_valid}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
